// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : uart_rx_fifo                                                     |
// | Purpose  : oversampling 8N1 UART receiver with majority vote, break/glitch  |
// |            handling and a show-ahead byte FIFO popped by ready/ack.         |
// | Options  : UART_RX_PARITY_EN adds an even-parity bit before the stop bit.   |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int BIT_PERIOD = 1250,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_pin_i,
    input  logic                     ack_i,
    output logic [7:0]               data_o,
    output logic                     ready_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     frame_err_o,
    output logic                     overflow_o,
    output logic                     parity_err_o
);
    localparam int c_TW = $clog2(BIT_PERIOD);
    localparam int c_AW = $clog2(DEPTH);

    localparam logic [c_TW-1:0] c_HALF = c_TW'(BIT_PERIOD / 2);
    localparam logic [c_TW-1:0] c_LAST = c_TW'(BIT_PERIOD - 1);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;
    localparam logic [2:0] c_BREAK  = 3'd5;

    logic [1:0]      sync_q;
    logic [2:0]      hist_q;
    logic [1:0]      warm_q;
    logic            armed_q;
    logic [2:0]      state_q, state_d;
    logic [c_TW-1:0] timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q;
    logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_AW:0]   count_q;
    logic [7:0]      mem_q [DEPTH];

    logic w_line, w_maj, w_fall, w_tick, w_par_ok, w_pop, w_push_ok;

    assign w_line = sync_q[1];
    assign w_maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    // The reset value of the sync chain is not a real observation of the line,
    // so a falling edge only counts once a genuine high has been seen.
    assign w_fall = armed_q & hist_q[1] & ~hist_q[0];
    assign w_tick = (timer_q == c_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;
    assign w_par_ok     = ((^shift_q) == par_q);
    assign parity_err_o = parity_err_q;
`else
    assign w_par_ok     = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            c_IDLE: begin
                timer_d = '0;
                if (w_fall) state_d = c_START;
            end
            c_START: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == c_HALF) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = w_maj ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                timer_d = w_tick ? '0 : timer_q + 1'b1;
                if (w_tick) begin
                    shift_d   = {w_maj, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = c_PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = c_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_PARITY: begin
                timer_d = w_tick ? '0 : timer_q + 1'b1;
                if (w_tick) begin
                    par_d   = w_maj;
                    state_d = c_STOP;
                end
            end
`endif
            c_STOP: begin
                timer_d = w_tick ? '0 : timer_q + 1'b1;
                if (w_tick) begin
                    if (w_maj) begin
                        state_d = c_IDLE;
                        if (w_par_ok) push_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        else parity_err_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = c_BREAK;
                    end
                end
            end
            c_BREAK: begin
                timer_d = '0;
                if (w_line) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            hist_q      <= 3'b111;
            warm_q      <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= c_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], rx_pin_i};
            hist_q      <= {hist_q[1:0], sync_q[1]};
            warm_q      <= (warm_q == 2'd3) ? warm_q : warm_q + 1'b1;
            armed_q     <= armed_q | ((warm_q == 2'd3) & hist_q[0]);
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // A full FIFO still takes the byte when the head is popped in the same cycle.
    assign w_pop     = ack_i & (count_q != '0);
    assign w_push_ok = push_q & ((count_q != c_FULL) | w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= push_q & ~w_push_ok;
            if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (w_push_ok & ~w_pop)      count_q <= count_q + 1'b1;
            else if (~w_push_ok & w_pop) count_q <= count_q - 1'b1;
        end
    end

    assign ready_o     = (count_q != '0);
    assign data_o      = ready_o ? mem_q[rd_ptr_q] : 8'h00;
    assign count_o     = count_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_uart_rx_fifo                                                  |
// | Purpose  : directed self-checking bench for uart_rx_fifo (BIT_PERIOD=16).   |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_uart_rx_fifo;
    localparam int BP    = 16;
    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam int c_STOP_DEC = 157 + BP;
`else
    localparam int c_STOP_DEC = 157;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] data;
    logic       ready;
    logic [3:0] count;
    logic       frame_err, overflow, parity_err;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int fe0, ov0, pe0;

    uart_rx_fifo #(.BIT_PERIOD(BP), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_pin_i     (rx),
        .ack_i        (ack),
        .data_o       (data),
        .ready_o      (ready),
        .count_o      (count),
        .frame_err_o  (frame_err),
        .overflow_o   (overflow),
        .parity_err_o (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1)  fe_cnt++;
        if (overflow === 1'b1)   ov_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
    end

    task automatic send(input logic [7:0] b, input logic par, input logic stop);
        @(posedge clk); #1 rx = 1'b0;
        repeat (BP) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (BP) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx = par;
        repeat (BP) @(posedge clk);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        #1 rx = stop;
        repeat (BP) @(posedge clk);
        #1;
    endtask

    task automatic pop1();
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
        n_cmp++; if ({frame_err, overflow, parity_err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 000", {frame_err, overflow, parity_err}); end
        rst = 1'b0;
        repeat (2 * BP) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send(8'h41, 1'b0, 1'b1);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready: got %b want 1", ready); end
        n_cmp++; if (data !== 8'h41) begin n_bad++; $display("FAIL basic_data: got %h want 41", data); end
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", count); end
        pop1();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL basic_pop_ready: got %b want 0", ready); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL basic_pop_count: got %0d want 0", count); end
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL basic_pop_data: got %h want 00", data); end
        // ack on an empty FIFO must be ignored
        pop1();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL empty_ack_count: got %0d want 0", count); end
    endtask

    task automatic test_glitch();
        fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * BP) @(posedge clk);
        #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL glitch_count: got %0d want 0", count); end
        n_cmp++; if ((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0) !== 0) begin
            n_bad++; $display("FAIL glitch_pulses: got %0d want 0", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)); end
        send(8'h5A, 1'b0, 1'b1);
        n_cmp++; if (data !== 8'h5A) begin n_bad++; $display("FAIL glitch_next_data: got %h want 5a", data); end
        pop1();
    endtask

    task automatic test_break();
        fe0 = fe_cnt;
        send(8'h55, 1'b0, 1'b0);
        repeat (20 * BP) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * BP) @(posedge clk);
        #1;
        n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL break_frame_err: got %0d want 1", fe_cnt - fe0); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL break_not_queued: got %0d want 0", count); end
        send(8'h33, 1'b0, 1'b1);
        n_cmp++; if (data !== 8'h33) begin n_bad++; $display("FAIL break_next_data: got %h want 33", data); end
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL break_next_count: got %0d want 1", count); end
        pop1();
    endtask

    task automatic test_overflow();
        ov0 = ov_cnt;
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send(b, ^b, 1'b1);
        end
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", count); end
        n_cmp++; if (ov_cnt - ov0 !== 1) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 1", ov_cnt - ov0); end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (data !== 8'(i)) begin n_bad++; $display("FAIL ovf_pop_order: got %h want %h", data, 8'(i)); end
            pop1();
        end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", ready); end
    endtask

    task automatic test_full_with_ack();
        ov0 = ov_cnt;
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send(b, ^b, 1'b1);
        end
        fork
            send(8'h09, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (c_STOP_DEC) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk); #1 ack = 1'b0;
            end
        join
        n_cmp++; if (ov_cnt - ov0 !== 0) begin n_bad++; $display("FAIL full_ack_overflow: got %0d want 0", ov_cnt - ov0); end
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_ack_count: got %0d want 8", count); end
        for (int i = 2; i <= 9; i++) begin
            n_cmp++; if (data !== 8'(i)) begin n_bad++; $display("FAIL full_ack_order: got %h want %h", data, 8'(i)); end
            pop1();
        end
    endtask

    task automatic test_parity();
        pe0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        n_cmp++; if (data !== 8'h07) begin n_bad++; $display("FAIL parity_good_data: got %h want 07", data); end
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL parity_good_count: got %0d want 1", count); end
        send(8'h07, 1'b0, 1'b1);
        n_cmp++; if (pe_cnt - pe0 !== 1) begin n_bad++; $display("FAIL parity_err_pulses: got %0d want 1", pe_cnt - pe0); end
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL parity_bad_count: got %0d want 1", count); end
        pop1();
`else
        send(8'h07, 1'b0, 1'b1);
        n_cmp++; if (data !== 8'h07) begin n_bad++; $display("FAIL noparity_data: got %h want 07", data); end
        n_cmp++; if (pe_cnt !== 0) begin n_bad++; $display("FAIL noparity_err: got %0d want 0", pe_cnt); end
        pop1();
`endif
    endtask

    task automatic test_reset_midframe();
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b1);
        n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL rstmid_queued: got %0d want 3", count); end
        fork
            send(8'h00, 1'b0, 1'b1);
            begin
                @(posedge clk);
                repeat (BP + 4 * BP + BP / 2) @(posedge clk);
                #1 rst = 1'b1;
                #1;
                n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", ready); end
                n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
                n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", data); end
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        repeat (12 * BP) @(posedge clk);
        #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rstmid_no_false_frame: got %0d want 0", count); end
        send(8'hA5, 1'b0, 1'b1);
        n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL rstmid_next_data: got %h want a5", data); end
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL rstmid_next_count: got %0d want 1", count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overflow();
        test_full_with_ack();
        test_parity();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
